channel: RTL and testbench



---
 rtl/channel.sv | 191 +++++++++++++++++++
 tb/tb_channel.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/channel.sv
// Single-entry handshake channel: decouples a sender handshake from a receiver
// handshake with one holding register, in four-phase or two-phase bundled-data style.
module channel #(
  parameter int WIDTH       = 13,
  parameter int HS_PROTOCOL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_req,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack,
  output logic             full,
  output logic [15:0]      xfer_cnt
);

  // Unknown protocol codes fall back to four-phase.
  localparam logic TWO_PHASE = (HS_PROTOCOL == 1);

  typedef enum logic {
    IN_IDLE,
    IN_ACKED
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_WAIT
  } out_state_e;

  in_state_e        in_state_q,  in_state_d;
  out_state_e       out_state_q, out_state_d;
  logic             s_ack_q,     s_ack_d;
  logic             r_req_q,     r_req_d;
  logic [WIDTH-1:0] r_data_q,    r_data_d;
  logic [WIDTH-1:0] hold_q,      hold_d;
  logic             full_q,      full_d;
  logic [15:0]      xfer_cnt_q,  xfer_cnt_d;
  logic             capture_s;
  logic             release_s;

  // Sender side: capture only when the registered entry is empty.
  always_comb begin
    in_state_d = in_state_q;
    s_ack_d    = s_ack_q;
    hold_d     = hold_q;
    capture_s  = 1'b0;
    if (TWO_PHASE) begin
      if ((s_req != s_ack_q) && !full_q) begin
        capture_s = 1'b1;
        hold_d    = s_data;
        s_ack_d   = ~s_ack_q;
      end else begin
        s_ack_d = s_ack_q;
      end
    end else begin
      case (in_state_q)
        IN_IDLE: begin
          if (s_req && !full_q) begin
            capture_s  = 1'b1;
            hold_d     = s_data;
            s_ack_d    = 1'b1;
            in_state_d = IN_ACKED;
          end else begin
            in_state_d = IN_IDLE;
          end
        end
        IN_ACKED: begin
          if (!s_req) begin
            s_ack_d    = 1'b0;
            in_state_d = IN_IDLE;
          end else begin
            in_state_d = IN_ACKED;
          end
        end
        default: begin
          s_ack_d    = 1'b0;
          in_state_d = IN_IDLE;
        end
      endcase
    end
  end

  // Receiver side: present the held word, free the entry once the handshake closes.
  always_comb begin
    out_state_d = out_state_q;
    r_req_d     = r_req_q;
    r_data_d    = r_data_q;
    release_s   = 1'b0;
    if (TWO_PHASE) begin
      case (out_state_q)
        OUT_IDLE: begin
          if (full_q && (r_req_q == r_ack)) begin
            r_req_d     = ~r_req_q;
            r_data_d    = hold_q;
            out_state_d = OUT_REQ;
          end else begin
            out_state_d = OUT_IDLE;
          end
        end
        OUT_REQ: begin
          if (r_ack == r_req_q) begin
            release_s   = 1'b1;
            out_state_d = OUT_IDLE;
          end else begin
            out_state_d = OUT_REQ;
          end
        end
        default: out_state_d = OUT_IDLE;
      endcase
    end else begin
      case (out_state_q)
        OUT_IDLE: begin
          if (full_q) begin
            r_req_d     = 1'b1;
            r_data_d    = hold_q;
            out_state_d = OUT_REQ;
          end else begin
            out_state_d = OUT_IDLE;
          end
        end
        OUT_REQ: begin
          if (r_ack) begin
            r_req_d     = 1'b0;
            out_state_d = OUT_WAIT;
          end else begin
            out_state_d = OUT_REQ;
          end
        end
        OUT_WAIT: begin
          if (!r_ack) begin
            release_s   = 1'b1;
            out_state_d = OUT_IDLE;
          end else begin
            out_state_d = OUT_WAIT;
          end
        end
        default: begin
          r_req_d     = 1'b0;
          out_state_d = OUT_IDLE;
        end
      endcase
    end
  end

  // Occupancy and transfer count; capture and release are mutually exclusive via full_q.
  always_comb begin
    full_d     = full_q;
    xfer_cnt_d = xfer_cnt_q;
    if (capture_s) begin
      full_d = 1'b1;
    end else if (release_s) begin
      full_d     = 1'b0;
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end else begin
      full_d = full_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
      s_ack_q     <= 1'b0;
      r_req_q     <= 1'b0;
      r_data_q    <= '0;
      hold_q      <= '0;
      full_q      <= 1'b0;
      xfer_cnt_q  <= 16'd0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      s_ack_q     <= s_ack_d;
      r_req_q     <= r_req_d;
      r_data_q    <= r_data_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign s_ack    = s_ack_q;
  assign r_req    = r_req_q;
  assign r_data   = r_data_q;
  assign full     = full_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_channel.sv
// Directed scoreboard bench for channel: a four-phase instance and a two-phase instance.
module tb_channel;

  localparam int W = 13;

  logic         clk;
  logic         rst_n;
  logic         s_req4, s_ack4, r_req4, r_ack4, full4;
  logic [W-1:0] s_data4, r_data4;
  logic [15:0]  cnt4;
  logic         s_req2, s_ack2, r_req2, r_ack2, full2;
  logic [W-1:0] s_data2, r_data2;
  logic [15:0]  cnt2;

  int           n_assert;
  int           n_fail;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] stream_vals[7];
  logic [W-1:0] tp_vals[3];

  channel #(.WIDTH(W), .HS_PROTOCOL(0)) u_fp (
    .clk(clk), .reset(rst_n), .s_req(s_req4), .s_data(s_data4), .s_ack(s_ack4),
    .r_req(r_req4), .r_data(r_data4), .r_ack(r_ack4), .full(full4), .xfer_cnt(cnt4)
  );

  channel #(.WIDTH(W), .HS_PROTOCOL(1)) u_tp (
    .clk(clk), .reset(rst_n), .s_req(s_req2), .s_data(s_data2), .s_ack(s_ack2),
    .r_req(r_req2), .r_data(r_data2), .r_ack(r_ack2), .full(full2), .xfer_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_exp();
    chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) exp_v = exp_q.pop_front();
    else exp_v = '0;
  endtask

  task automatic fp_send(input logic [W-1:0] v);
    s_data4 = v;
    s_req4  = 1'b1;
    exp_q.push_back(v);
    for (int i = 0; i < 20 && !s_ack4; i++) @(negedge clk);
    chk("fp_s_ack_rise", 32'(s_ack4), 32'd1);
    s_req4 = 1'b0;
    for (int i = 0; i < 20 && s_ack4; i++) @(negedge clk);
    chk("fp_s_ack_fall", 32'(s_ack4), 32'd0);
  endtask

  task automatic fp_recv();
    for (int i = 0; i < 20 && !r_req4; i++) @(negedge clk);
    chk("fp_r_req_rise", 32'(r_req4), 32'd1);
    pop_exp();
    chk("fp_r_data", 32'(r_data4), 32'(exp_v));
    r_ack4 = 1'b1;
    for (int i = 0; i < 20 && r_req4; i++) @(negedge clk);
    chk("fp_r_req_fall", 32'(r_req4), 32'd0);
    r_ack4 = 1'b0;
    for (int i = 0; i < 20 && full4; i++) @(negedge clk);
    chk("fp_full_clear", 32'(full4), 32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    stream_vals = '{13'd28, 13'd10, 13'd236, 13'd102, 13'd54, 13'd16, 13'd154};
    tp_vals     = '{13'h1FFF, 13'h0000, 13'h0005};
    rst_n   = 1'b0;
    s_req4  = 1'b0; s_data4 = '0; r_ack4 = 1'b0;
    s_req2  = 1'b0; s_data2 = '0; r_ack2 = 1'b0;
    repeat (3) @(negedge clk);

    // reset values on both instances
    chk("rst_s_ack4", 32'(s_ack4), 32'd0);
    chk("rst_r_req4", 32'(r_req4), 32'd0);
    chk("rst_r_data4", 32'(r_data4), 32'd0);
    chk("rst_full4", 32'(full4), 32'd0);
    chk("rst_cnt4", 32'(cnt4), 32'd0);
    chk("rst_s_ack2", 32'(s_ack2), 32'd0);
    chk("rst_r_req2", 32'(r_req2), 32'd0);
    chk("rst_full2", 32'(full2), 32'd0);
    chk("rst_cnt2", 32'(cnt2), 32'd0);

    // single value 28, request already pending at reset release
    s_data4 = 13'd28;
    s_req4  = 1'b1;
    exp_q.push_back(13'd28);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lat_s_ack", 32'(s_ack4), 32'd1);
    chk("lat_full", 32'(full4), 32'd1);
    chk("lat_r_req_early", 32'(r_req4), 32'd0);
    @(negedge clk);
    chk("lat_r_req", 32'(r_req4), 32'd1);
    pop_exp();
    chk("lat_r_data", 32'(r_data4), 32'(exp_v));
    r_ack4 = 1'b1;
    @(negedge clk);
    chk("lat_r_req_fall", 32'(r_req4), 32'd0);
    s_req4 = 1'b0;
    r_ack4 = 1'b0;
    @(negedge clk);
    chk("lat_full_clear", 32'(full4), 32'd0);
    chk("lat_s_ack_fall", 32'(s_ack4), 32'd0);
    chk("lat_cnt", 32'(cnt4), 32'd1);

    // stream with ideal receiver: seven more transfers on top of the first
    for (int k = 0; k < 7; k++) begin
      fp_send(stream_vals[k]);
      fp_recv();
    end
    chk("stream_cnt", 32'(cnt4), 32'd8);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // backpressure: entry held, second value must wait
    fp_send(13'd100);
    s_data4 = 13'd200;
    s_req4  = 1'b1;
    exp_q.push_back(13'd200);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_s_ack_held", 32'(s_ack4), 32'd0);
      chk("bp_r_data_stable", 32'(r_data4), 32'd100);
    end
    fp_recv();
    chk("bp_idle_gap", 32'(s_ack4), 32'd0);
    @(negedge clk);
    chk("bp_second_capture", 32'(s_ack4), 32'd1);
    chk("bp_second_full", 32'(full4), 32'd1);
    s_req4 = 1'b0;
    for (int i = 0; i < 20 && s_ack4; i++) @(negedge clk);
    fp_recv();
    chk("bp_cnt", 32'(cnt4), 32'd10);

    // reset in the middle of a transfer
    fp_send(13'd236);
    for (int i = 0; i < 20 && !r_req4; i++) @(negedge clk);
    chk("mid_r_req", 32'(r_req4), 32'd1);
    chk("mid_r_data", 32'(r_data4), 32'd236);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s_ack", 32'(s_ack4), 32'd0);
    chk("mid_rst_r_req", 32'(r_req4), 32'd0);
    chk("mid_rst_r_data", 32'(r_data4), 32'd0);
    chk("mid_rst_full", 32'(full4), 32'd0);
    chk("mid_rst_cnt", 32'(cnt4), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    fp_send(13'd54);
    fp_recv();
    chk("post_rst_cnt", 32'(cnt4), 32'd1);

    // counter wrap: preload near the top, then finish with real transfers
    @(negedge clk);
    force u_fp.xfer_cnt_q = 16'hFFFD;
    @(posedge clk);
    #1;
    release u_fp.xfer_cnt_q;
    chk("wrap_preload", 32'(cnt4), 32'h0000FFFD);
    fp_send(13'd1); fp_recv();
    fp_send(13'd2); fp_recv();
    chk("wrap_top", 32'(cnt4), 32'h0000FFFF);
    fp_send(13'd3); fp_recv();
    chk("wrap_zero", 32'(cnt4), 32'd0);

    // two-phase transfers
    for (int k = 0; k < 3; k++) begin
      s_data2 = tp_vals[k];
      s_req2  = ~s_req2;
      exp_q.push_back(tp_vals[k]);
      for (int i = 0; i < 20 && (s_ack2 != s_req2); i++) @(negedge clk);
      chk("tp_s_ack_toggle", 32'(s_ack2), 32'(s_req2));
      for (int i = 0; i < 20 && (r_req2 == r_ack2); i++) @(negedge clk);
      chk("tp_r_req_toggle", 32'(r_req2 != r_ack2), 32'd1);
      pop_exp();
      chk("tp_r_data", 32'(r_data2), 32'(exp_v));
      r_ack2 = r_req2;
      for (int i = 0; i < 20 && full2; i++) @(negedge clk);
      chk("tp_full_clear", 32'(full2), 32'd0);
    end
    chk("tp_s_ack_final", 32'(s_ack2), 32'd1);
    chk("tp_r_req_final", 32'(r_req2), 32'd1);
    chk("tp_cnt", 32'(cnt2), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
